wb_write_queue: RTL and testbench
=================================

Name: wb_write_queue

Overview:
- Writer-side front end for the 16-entry, 16-bit register file write port (DstReg/WriteReg/DstData).
- Collects completed results from two producers, the ALU path and the memory/load path (which may complete late), into an in-order FIFO.
- Drains the FIFO to the register file at one write per cycle.
- Provides a pending-write lookup for the two decode-stage source IDs so the pipeline can forward or stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DW, 16, data width
- AW, 4, register ID width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_valid  in  1  memory-path result valid
- mem_reg  in  AW  memory-path destination ID
- mem_data  in  DW  memory-path result
- alu_valid  in  1  ALU-path result valid
- alu_reg  in  AW  ALU-path destination ID
- alu_data  in  DW  ALU-path result
- in_ready  out  1  both producers may present this cycle
- hold  in  1  freeze drain (debug/flush control)
- DstReg  out  AW  register file write ID
- WriteReg  out  1  register file write enable
- DstData  out  DW  register file write data
- SrcReg1  in  AW  decode source ID 1
- SrcReg2  in  AW  decode source ID 2
- pend_hit1  out  1  SrcReg1 has a pending write
- pend_hit2  out  1  SrcReg2 has a pending write
- fwd_data1  out  DW  youngest pending data for SrcReg1
- fwd_data2  out  DW  youngest pending data for SrcReg2
- count  out  log2(DEPTH)+1  occupancy

Behaviour:
- **Reset.** Asynchronous on rst_n low; count, head and tail pointers clear to 0; all entry valid bits clear. Outputs while in reset or empty: WriteReg=0, DstReg=0, DstData=0, pend_hit*=0, fwd_data*=0, in_ready=1.
- **Storage.** Circular buffer with head/tail pointers of log2(DEPTH) bits each, wrapping modulo DEPTH. count tracks occupancy (0..DEPTH).
- **Enqueue.**
  - A producer is accepted when its valid=1 and in_ready=1.
  - Writes with reg ID 0 are dropped and never enqueued; register 0 always reads zero.
  - If both producers are accepted in the same cycle, the mem entry is written at tail and the ALU entry at tail+1, because the mem result is the older instruction.
- **in_ready.** Combinational from count only: in_ready = (count ≤ DEPTH-2). It has no dependency on same-cycle drain. Producers presenting valid while in_ready=0 are ignored; producers must hold their values.
- **Drain.**
  - When count>0 and hold=0: WriteReg=1, DstReg and DstData come from the head entry, driven from flops (no combinational path from producer inputs). head advances at the clock edge.
  - When hold=1 or count=0: WriteReg=0 and DstReg/DstData=0.
- **Latency.** An entry enqueued at edge N is visible on the write port in cycle N+1 at the earliest, if it is at head.
- **Simultaneous enqueue and drain.** count_next = count + accepted − drained.
- **Lookup.**
  - All stored valid entries, including the head being drained this cycle, are compared against SrcRegX.
  - The youngest match (closest to tail) supplies fwd_dataX.
  - SrcRegX=0 never hits.
  - Same-cycle producer inputs are not searched.
- **Overflow/underflow.** Cannot occur by construction. An assertion must fire if count would exceed DEPTH or go negative.
- **Reset mid-operation.** All pending entries are discarded. WriteReg drops in the same cycle that rst_n goes low.

Optional Feature:
- Macro: WBQ_FORWARD_EN.
- Defined: fwd_data1/2 carry the youngest matching pending data as described above.
- Undefined:
  - fwd_data1/2 are tied to 0 and the data-select mux is not built.
  - pend_hit1/2 remain active and are used by the pipeline purely as stall requests.

Test Plan:
- Reset then idle: rst_n low, release → WriteReg=0, count=0, in_ready=1, pend_hit*=0.
- Single ALU write: alu_valid=1, alu_reg=5, alu_data=16'hBEEF at edge 1 → cycle 2: WriteReg=1, DstReg=5, DstData=16'hBEEF; cycle 3: count=0, WriteReg=0.
- Dual enqueue ordering: mem (3, 16'h1111) and ALU (3, 16'h2222) in the same cycle.
  - Next cycle: pend_hit1=1 for SrcReg1=3, fwd_data1=16'h2222.
  - Write port sequence: DstData=1111 then 2222.
- Full/backpressure: hold=1, enqueue 2 pairs with DEPTH=4 → count=4, in_ready=0; a further valid is ignored. Release hold → 4 writes in order, in_ready returns to 1 once count≤2.
- Register 0 drop: alu_reg=0, data 16'hFFFF → count stays 0, WriteReg never asserted; SrcReg2=0 → pend_hit2=0.
- Reset mid-drain: 3 entries pending, rst_n low for 1 cycle → WriteReg=0 immediately, count=0; no further writes after release.

Source files
------------

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port, with a pending-write lookup.
// Define WBQ_FORWARD_EN to build the forwarding data mux; otherwise fwd_data1/2 are tied to zero.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  output logic          in_ready,
  input  logic          hold,
  output logic [AW-1:0] DstReg,
  output logic          WriteReg,
  output logic [DW-1:0] DstData,
  input  logic [AW-1:0] SrcReg1,
  input  logic [AW-1:0] SrcReg2,
  output logic          pend_hit1,
  output logic          pend_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count
);

  logic [AW-1:0] reg_q   [DEPTH];
  logic [AW-1:0] reg_d   [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, alu_slot, scan_idx;
  logic [CW-1:0] count_q, count_d;
  logic          mem_acc, alu_acc, drain;
  logic [1:0]    n_acc;

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign mem_acc  = mem_valid && in_ready && (mem_reg != '0);
  assign alu_acc  = alu_valid && in_ready && (alu_reg != '0);
  assign n_acc    = {1'b0, mem_acc} + {1'b0, alu_acc};
  assign drain    = (count_q != '0) && !hold;
  assign alu_slot = tail_q + PW'(mem_acc);

  assign WriteReg = drain;
  assign DstReg   = drain ? reg_q[head_q] : '0;
  assign DstData  = drain ? data_q[head_q] : '0;
  assign count    = count_q;

  // The mem result is the older instruction, so it takes the tail slot ahead of the ALU result.
  always_comb begin
    reg_d   = reg_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (drain) valid_d[head_q] = 1'b0;
    if (mem_acc) begin
      reg_d[tail_q]   = mem_reg;
      data_d[tail_q]  = mem_data;
      valid_d[tail_q] = 1'b1;
    end
    if (alu_acc) begin
      reg_d[alu_slot]   = alu_reg;
      data_d[alu_slot]  = alu_data;
      valid_d[alu_slot] = 1'b1;
    end
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(n_acc);
    count_d = count_q + CW'(n_acc) - CW'(drain);
  end

  // Scanning oldest to youngest lets the last match win, giving the youngest pending data.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (valid_q[scan_idx] && (SrcReg1 != '0) && (reg_q[scan_idx] == SrcReg1)) begin
        pend_hit1 = 1'b1;
`ifdef WBQ_FORWARD_EN
        fwd_data1 = data_q[scan_idx];
`endif
      end
      if (valid_q[scan_idx] && (SrcReg2 != '0) && (reg_q[scan_idx] == SrcReg2)) begin
        pend_hit2 = 1'b1;
`ifdef WBQ_FORWARD_EN
        fwd_data2 = data_q[scan_idx];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  occupancy_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    ((int'(count_q) + int'(n_acc) - int'(drain)) >= 0) &&
    ((int'(count_q) + int'(n_acc) - int'(drain)) <= DEPTH));

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4); expected values are hand-computed.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid, hold;
  logic [3:0]  mem_reg, alu_reg, SrcReg1, SrcReg2, DstReg;
  logic [15:0] mem_data, alu_data, DstData, fwd_data1, fwd_data2;
  logic        in_ready, WriteReg, pend_hit1, pend_hit2;
  logic [2:0]  count;

  int errorCount = 0;
  int checkCount = 0;
  logic [15:0] expFwd;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(4), .DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .in_ready(in_ready), .hold(hold),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents both producers for one clock edge, then withdraws them.
  task automatic applyStimulus(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                               input logic av, input logic [3:0] ar, input logic [15:0] ad);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkPort(input string tag, input logic we, input logic [3:0] dr,
                           input logic [15:0] dd, input logic [2:0] cnt);
    checkOutput({tag, ".WriteReg"}, 32'(WriteReg), 32'(we));
    checkOutput({tag, ".DstReg"},   32'(DstReg),   32'(dr));
    checkOutput({tag, ".DstData"},  32'(DstData),  32'(dd));
    checkOutput({tag, ".count"},    32'(count),    32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    SrcReg1 = 4'd3; SrcReg2 = 4'd0;

    step(); step();
    checkPort("reset", 1'b0, 4'd0, 16'h0, 3'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.pend_hit1", 32'(pend_hit1), 32'd0);
    rst_n = 1'b1;
    step();
    checkPort("idle", 1'b0, 4'd0, 16'h0, 3'd0);
    checkOutput("idle.pend_hit2", 32'(pend_hit2), 32'd0);
    checkOutput("idle.fwd_data1", 32'(fwd_data1), 32'd0);

    SrcReg1 = 4'd5;
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'hBEEF);
    checkPort("single", 1'b1, 4'd5, 16'hBEEF, 3'd1);
    checkOutput("single.pend_hit1", 32'(pend_hit1), 32'd1);
    step();
    checkPort("single_done", 1'b0, 4'd0, 16'h0, 3'd0);
    checkOutput("single_done.pend_hit1", 32'(pend_hit1), 32'd0);

`ifdef WBQ_FORWARD_EN
    expFwd = 16'h2222;
`else
    expFwd = 16'h0000;
`endif
    SrcReg1 = 4'd3;
    applyStimulus(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222);
    checkPort("dual0", 1'b1, 4'd3, 16'h1111, 3'd2);
    checkOutput("dual0.pend_hit1", 32'(pend_hit1), 32'd1);
    checkOutput("dual0.fwd_data1", 32'(fwd_data1), 32'(expFwd));
    step();
    checkPort("dual1", 1'b1, 4'd3, 16'h2222, 3'd1);
    checkOutput("dual1.pend_hit1", 32'(pend_hit1), 32'd1);
    checkOutput("dual1.fwd_data1", 32'(fwd_data1), 32'(expFwd));
    step();
    checkPort("dual_done", 1'b0, 4'd0, 16'h0, 3'd0);
    checkOutput("dual_done.pend_hit1", 32'(pend_hit1), 32'd0);

    hold = 1'b1;
    applyStimulus(1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hA002);
    checkPort("fill2", 1'b0, 4'd0, 16'h0, 3'd2);
    checkOutput("fill2.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 4'd3, 16'hA003, 1'b1, 4'd4, 16'hA004);
    checkPort("fill4", 1'b0, 4'd0, 16'h0, 3'd4);
    checkOutput("fill4.in_ready", 32'(in_ready), 32'd0);
    SrcReg1 = 4'd4; SrcReg2 = 4'd6;
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 16'hA006);
    checkPort("ignored", 1'b0, 4'd0, 16'h0, 3'd4);
    checkOutput("ignored.pend_hit2", 32'(pend_hit2), 32'd0);
    checkOutput("ignored.pend_hit1", 32'(pend_hit1), 32'd1);
`ifdef WBQ_FORWARD_EN
    expFwd = 16'hA004;
`else
    expFwd = 16'h0000;
`endif
    checkOutput("ignored.fwd_data1", 32'(fwd_data1), 32'(expFwd));
    hold = 1'b0;
    #1;
    checkPort("drain1", 1'b1, 4'd1, 16'hA001, 3'd4);
    checkOutput("drain1.in_ready", 32'(in_ready), 32'd0);
    step();
    checkPort("drain2", 1'b1, 4'd2, 16'hA002, 3'd3);
    checkOutput("drain2.in_ready", 32'(in_ready), 32'd0);
    step();
    checkPort("drain3", 1'b1, 4'd3, 16'hA003, 3'd2);
    checkOutput("drain3.in_ready", 32'(in_ready), 32'd1);
    step();
    checkPort("drain4", 1'b1, 4'd4, 16'hA004, 3'd1);
    step();
    checkPort("drain_done", 1'b0, 4'd0, 16'h0, 3'd0);

    SrcReg2 = 4'd0;
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF);
    checkPort("reg0", 1'b0, 4'd0, 16'h0, 3'd0);
    checkOutput("reg0.pend_hit2", 32'(pend_hit2), 32'd0);
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd7, 16'h7777);
    checkPort("reg0_mix", 1'b1, 4'd7, 16'h7777, 3'd1);
    step();
    checkPort("reg0_mix_done", 1'b0, 4'd0, 16'h0, 3'd0);

    hold = 1'b1;
    applyStimulus(1'b1, 4'd8, 16'h8888, 1'b1, 4'd9, 16'h9999);
    applyStimulus(1'b1, 4'd10, 16'hAAAA, 1'b0, 4'd0, 16'h0);
    checkPort("pre_reset", 1'b0, 4'd0, 16'h0, 3'd3);
    hold = 1'b0;
    #1;
    checkPort("mid_drain", 1'b1, 4'd8, 16'h8888, 3'd3);
    rst_n = 1'b0;
    #1;
    checkPort("async_reset", 1'b0, 4'd0, 16'h0, 3'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkPort("post_reset", 1'b0, 4'd0, 16'h0, 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
